// File: rtl/period_sel_timer.sv
// Switch-selected periodic tick generator: one-cycle tick plus toggle from one of four periods.
// Optional PERIOD_SEL_SYNC_EN adds a two-flop synchronizer on i_sw for asynchronous switch inputs.
module period_sel_timer #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned R0        = 3,
    parameter int unsigned R1        = 10,
    parameter int unsigned R2        = 100,
    parameter int unsigned R3        = 5000
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [1:0]           i_sw,
    input  logic                 i_enable,
    input  logic                 i_restart,
    output logic                 o_tick,
    output logic                 o_toggle,
    output logic [1:0]           o_sel,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam int unsigned R_ARR [4] = '{R0, R1, R2, R3};

    logic [CNT_WIDTH-1:0] last_val [4];
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [1:0]           sel_q, sel_d;
    logic                 tick_q, tick_d;
    logic                 toggle_q, toggle_d;
    logic [1:0]           sw_s;
    logic                 at_last;

    // Terminal count per selection; a period truncating to 0 behaves as period 1.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_period
            localparam logic [CNT_WIDTH-1:0] TRUNC = CNT_WIDTH'(R_ARR[gi]);
            assign last_val[gi] = (TRUNC == '0) ? '0 : TRUNC - ONE;
        end
    endgenerate

`ifdef PERIOD_SEL_SYNC_EN
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= i_sw;
            sync2_q <= sync1_q;
        end
    end

    assign sw_s = sync2_q;
`else
    assign sw_s = i_sw;
`endif

    assign at_last = (count_q == last_val[sel_q]);

    // Selection is only re-sampled at a wrap or restart, so a period is never truncated.
    always_comb begin
        count_d  = count_q;
        sel_d    = sel_q;
        toggle_d = toggle_q;
        tick_d   = 1'b0;
        if (i_restart) begin
            count_d = '0;
            sel_d   = sw_s;
        end else if (i_enable) begin
            if (at_last) begin
                count_d  = '0;
                tick_d   = 1'b1;
                toggle_d = ~toggle_q;
                sel_d    = sw_s;
            end else begin
                count_d = count_q + ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            sel_q    <= 2'b00;
            tick_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            sel_q    <= sel_d;
            tick_q   <= tick_d;
            toggle_q <= toggle_d;
        end
    end

    assign o_count  = count_q;
    assign o_sel    = sel_q;
    assign o_tick   = tick_q;
    assign o_toggle = toggle_q;

endmodule

// File: tb/tb_period_sel_timer.sv
// Scoreboard bench for period_sel_timer: a default-period instance and a small-width
// instance with degenerate/truncated periods share stimulus and are checked against a model.
module tb_period_sel_timer;

    logic       clk;
    logic       rst_n;
    logic [1:0] sw;
    logic       en;
    logic       restart;

    logic        tick0, toggle0;
    logic [1:0]  sel0;
    logic [31:0] count0;
    logic        tick1, toggle1;
    logic [1:0]  sel1;
    logic [7:0]  count1;

    period_sel_timer #(.CNT_WIDTH(32), .R0(3), .R1(10), .R2(100), .R3(5000)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_enable(en), .i_restart(restart),
        .o_tick(tick0), .o_toggle(toggle0), .o_sel(sel0), .o_count(count0)
    );

    period_sel_timer #(.CNT_WIDTH(8), .R0(0), .R1(1), .R2(256), .R3(300)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sw(sw), .i_enable(en), .i_restart(restart),
        .o_tick(tick1), .o_toggle(toggle1), .o_sel(sel1), .o_count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [31:0] count;
        logic        tick;
        logic        toggle;
        logic [1:0]  sel;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model state: period lengths per instance and select, plus abstract timer state.
    longint unsigned per_m [2][4];
    longint unsigned m_count [2];
    bit              m_tick [2];
    bit              m_toggle [2];
    bit [1:0]        m_sel [2];
    bit [1:0]        sw_hist1, sw_hist2;

    function automatic longint unsigned eff_period(longint unsigned r, int w);
        longint unsigned t;
        t = r % (64'd1 << w);
        return (t == 0) ? 64'd1 : t;
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e.dut    = d;
            e.count  = m_count[d][31:0];
            e.tick   = m_tick[d];
            e.toggle = m_toggle[d];
            e.sel    = m_sel[d];
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_count[d]  = 0;
            m_tick[d]   = 1'b0;
            m_toggle[d] = 1'b0;
            m_sel[d]    = 2'b00;
        end
        sw_hist1 = 2'b00;
        sw_hist2 = 2'b00;
    endtask

    // One clock edge of the reference timer, using the select value seen after sync latency.
    task automatic model_edge(bit [1:0] sw_v, bit en_v, bit rs_v);
        bit [1:0] sws;
`ifdef PERIOD_SEL_SYNC_EN
        sws = sw_hist2;
`else
        sws = sw_v;
`endif
        sw_hist2 = sw_hist1;
        sw_hist1 = sw_v;
        for (int d = 0; d < 2; d++) begin
            m_tick[d] = 1'b0;
            if (rs_v) begin
                m_count[d] = 0;
                m_sel[d]   = sws;
            end else if (en_v) begin
                if (m_count[d] + 1 >= per_m[d][m_sel[d]]) begin
                    m_count[d]  = 0;
                    m_tick[d]   = 1'b1;
                    m_toggle[d] = !m_toggle[d];
                    m_sel[d]    = sws;
                end else begin
                    m_count[d] = m_count[d] + 1;
                end
            end
        end
        push_expect();
    endtask

    task automatic cycle(bit [1:0] sw_v, bit en_v, bit rs_v);
        @(negedge clk);
        rst_n   = 1'b1;
        sw      = sw_v;
        en      = en_v;
        restart = rs_v;
        model_edge(sw_v, en_v, rs_v);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        push_expect();
        repeat (2) @(negedge clk);
    endtask

    // Monitor: outputs are presented after every clock edge and on reset assertion.
    initial begin
        exp_t        e;
        logic [31:0] a_count;
        logic        a_tick, a_toggle;
        logic [1:0]  a_sel;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.dut == 0) begin
                    a_count = count0; a_tick = tick0; a_toggle = toggle0; a_sel = sel0;
                end else begin
                    a_count = {24'd0, count1}; a_tick = tick1; a_toggle = toggle1; a_sel = sel1;
                end
                tests_run++;
                if (a_count !== e.count || a_tick !== e.tick || a_toggle !== e.toggle || a_sel !== e.sel) begin
                    tests_failed++;
                    $display("FAIL dut%0d_outputs t=%0t: got count=%0d tick=%b toggle=%b sel=%0d, required count=%0d tick=%b toggle=%b sel=%0d",
                             e.dut, $time, a_count, a_tick, a_toggle, a_sel,
                             e.count, e.tick, e.toggle, e.sel);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        per_m[0][0] = eff_period(3, 32);    per_m[0][1] = eff_period(10, 32);
        per_m[0][2] = eff_period(100, 32);  per_m[0][3] = eff_period(5000, 32);
        per_m[1][0] = eff_period(0, 8);     per_m[1][1] = eff_period(1, 8);
        per_m[1][2] = eff_period(256, 8);   per_m[1][3] = eff_period(300, 8);

        rst_n = 1'b1; sw = 2'b00; en = 1'b0; restart = 1'b0;
        model_reset();

        // Reset, then free-run on R0: ticks every 3 edges.
        apply_reset();
        repeat (12) cycle(2'b00, 1'b1, 1'b0);

        // Reset asserted mid-count.
        cycle(2'b00, 1'b1, 1'b0);
        apply_reset();
        repeat (10) cycle(2'b00, 1'b1, 1'b0);

        // Mid-period select change to the long period.
        apply_reset();
        cycle(2'b00, 1'b1, 1'b0);
        repeat (5010) cycle(2'b11, 1'b1, 1'b0);

        // Restart on the same edge as the wrap under R1.
        repeat (3) cycle(2'b01, 1'b0, 1'b0);
        cycle(2'b01, 1'b1, 1'b1);
        repeat (9) cycle(2'b01, 1'b1, 1'b0);
        cycle(2'b01, 1'b1, 1'b1);
        repeat (4) cycle(2'b01, 1'b1, 1'b0);

        // Enable gating at count 5 under R1.
        cycle(2'b01, 1'b1, 1'b1);
        repeat (5) cycle(2'b01, 1'b1, 1'b0);
        repeat (7) cycle(2'b01, 1'b0, 1'b0);
        repeat (15) cycle(2'b01, 1'b1, 1'b0);

        // Degenerate periods on the narrow instance, select 0.
        repeat (3) cycle(2'b00, 1'b0, 1'b0);
        cycle(2'b00, 1'b1, 1'b1);
        repeat (8) cycle(2'b00, 1'b1, 1'b0);

        // Select change arriving together with a restart.
        cycle(2'b10, 1'b1, 1'b1);
        cycle(2'b10, 1'b1, 1'b1);
        cycle(2'b10, 1'b1, 1'b1);
        repeat (5) cycle(2'b10, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                apply_reset();
            end else begin
                cycle(2'($urandom_range(0, 3)),
                      ($urandom_range(0, 9) < 8),
                      ($urandom_range(0, 99) < 3));
            end
        end

        @(negedge clk);
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
